word_scroller: RTL and testbench

Parametrised scrolling-message engine for the seven-segment word display path. Holds a writable message of MSG_LEN character codes plus PAD_LEN blank slots as a circular ring. It rotates the ring across NUM_DISP display positions on an internal prescaled step. It supports left and right scroll, hold, and one-shot (single revolution) modes, and drives the per-display character codes consumed by the existing character-to-segment decoders.

---
 rtl/scroll_pkg.sv | 19 +
 rtl/char_mux_nto1.sv | 23 ++
 rtl/word_scroller.sv | 188 ++++++++++++++++++
 tb/tb_word_scroller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling word display: mode codes, FSM
// state encoding and the default blank character code.
package scroll_pkg;

    localparam logic [1:0] MODE_HOLD    = 2'b00;
    localparam logic [1:0] MODE_LEFT    = 2'b01;
    localparam logic [1:0] MODE_RIGHT   = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    typedef enum logic [1:0] {
        ST_STOP    = 2'b00,
        ST_SCROLL  = 2'b01,
        ST_ONESHOT = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    localparam logic [2:0] DEFAULT_BLANK = 3'b111;

endpackage

// File: rtl/char_mux_nto1.sv
// Combinational N-to-1 character selector. Generalises the old fixed
// 8-to-1 display mux; one instance drives each display position.
module char_mux_nto1 #(
    parameter  int CHAR_W = 3,
    parameter  int N      = 8,
    localparam int SEL_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N*CHAR_W-1:0] data_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic [CHAR_W-1:0]   char_o
);

    // Pick slot sel_i out of the flattened input vector.
    always_comb begin
        char_o = data_i[CHAR_W-1:0];
        for (int j = 0; j < N; j++) begin
            if (sel_i == SEL_W'(j)) begin
                char_o = data_i[j*CHAR_W +: CHAR_W];
            end
        end
    end

endmodule

// File: rtl/word_scroller.sv
// Scrolling-message engine: a writable message plus blank padding forms a
// circular ring that is rotated across the display positions on a
// prescaled step. Disp is computed from next-state offset and message so
// that it is registered on the same edge as Offset.
module word_scroller
    import scroll_pkg::*;
#(
    parameter  int                CHAR_W   = 3,
    parameter  int                MSG_LEN  = 5,
    parameter  int                PAD_LEN  = 3,
    parameter  int                NUM_DISP = 8,
    parameter  int                TICK_DIV = 25_000_000,
    parameter  logic [CHAR_W-1:0] BLANK    = CHAR_W'(DEFAULT_BLANK),
    localparam int                RING_LEN = MSG_LEN + PAD_LEN,
    localparam int                AW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    localparam int                OW       = $clog2(RING_LEN),
    localparam int                PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic [1:0]                 Mode,
    input  logic                       Restart,
    input  logic                       WrEn,
    input  logic [AW-1:0]              WrAddr,
    input  logic [CHAR_W-1:0]          WrData,
    output logic [NUM_DISP*CHAR_W-1:0] Disp,
    output logic [OW-1:0]              Offset,
    output logic                       Step,
    output logic                       Wrap,
    output logic                       Done
);

    logic [CHAR_W-1:0]          msg_q [MSG_LEN];
    logic [CHAR_W-1:0]          msg_d [MSG_LEN];
    logic [CHAR_W-1:0]          ring_d [RING_LEN];
    state_t                     state_q, state_d;
    logic [PW-1:0]              pres_q, pres_d, pres_inc;
    logic [OW-1:0]              off_q, off_d, off_inc, off_dec;
    logic                       step_q, step_d;
    logic                       wrap_q, wrap_d;
    logic                       done_q, done_d;
    logic [NUM_DISP*CHAR_W-1:0] disp_q, disp_d;
    logic                       tick, last;

    assign tick     = (pres_q == PW'(TICK_DIV - 1));
    assign last     = (off_q == OW'(RING_LEN - 1));
    assign pres_inc = tick ? '0 : pres_q + PW'(1);
    assign off_inc  = last ? '0 : off_q + OW'(1);
    assign off_dec  = (off_q == '0) ? OW'(RING_LEN - 1) : off_q - OW'(1);

    // Message write port; out-of-range addresses are dropped.
    always_comb begin
        msg_d = msg_q;
        if (WrEn && (int'(WrAddr) < MSG_LEN)) begin
            msg_d[WrAddr] = WrData;
        end
    end

    // Mode-driven FSM: prescaler, offset counter and pulse generation.
    always_comb begin
        state_d = state_q;
        pres_d  = pres_q;
        off_d   = off_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = done_q;
        case (Mode)
            MODE_HOLD: begin
                state_d = ST_STOP;
                pres_d  = '0;
                done_d  = 1'b0;
                if (Restart) off_d = '0;
            end
            MODE_LEFT, MODE_RIGHT: begin
                // Prescaler is kept when flipping direction.
                state_d = ST_SCROLL;
                done_d  = 1'b0;
                if (Restart) begin
                    off_d  = '0;
                    pres_d = '0;
                end else begin
                    pres_d = pres_inc;
                    if (tick) begin
                        step_d = 1'b1;
                        if (Mode == MODE_LEFT) begin
                            off_d  = off_inc;
                            wrap_d = last;
                        end else begin
                            off_d  = off_dec;
                            wrap_d = (off_q == '0);
                        end
                    end
                end
            end
            default: begin
                case (state_q)
                    ST_ONESHOT: begin
                        if (Restart) begin
                            off_d  = '0;
                            pres_d = '0;
                        end else begin
                            pres_d = pres_inc;
                            if (tick) begin
                                step_d = 1'b1;
                                off_d  = off_inc;
                                if (last) begin
                                    wrap_d  = 1'b1;
                                    state_d = ST_DONE;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        if (Restart) begin
                            state_d = ST_ONESHOT;
                            done_d  = 1'b0;
                            off_d   = '0;
                            pres_d  = '0;
                        end
                    end
                    default: begin
                        // Entering a revolution always starts from slot 0.
                        state_d = ST_ONESHOT;
                        pres_d  = '0;
                        off_d   = '0;
                        done_d  = 1'b0;
                    end
                endcase
            end
        endcase
    end

    // Ring view of the next message: pad slots are fixed BLANK.
    for (genvar i = 0; i < RING_LEN; i++) begin : g_ring
        if (i < MSG_LEN) begin : g_msg
            assign ring_d[i] = msg_d[i];
        end else begin : g_pad
            assign ring_d[i] = BLANK;
        end
    end

    // Each position sees the ring rotated by its index, selected by offset.
    for (genvar k = 0; k < NUM_DISP; k++) begin : g_pos
        logic [RING_LEN*CHAR_W-1:0] rot;
        for (genvar j = 0; j < RING_LEN; j++) begin : g_rot
            assign rot[j*CHAR_W +: CHAR_W] = ring_d[(j + k) % RING_LEN];
        end
        char_mux_nto1 #(
            .CHAR_W (CHAR_W),
            .N      (RING_LEN)
        ) u_mux (
            .data_i (rot),
            .sel_i  (off_d),
            .char_o (disp_d[k*CHAR_W +: CHAR_W])
        );
    end

    // State and output registers; reset blanks the message immediately.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_STOP;
            pres_q  <= '0;
            off_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= {NUM_DISP{BLANK}};
            for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= BLANK;
        end else begin
            state_q <= state_d;
            pres_q  <= pres_d;
            off_q   <= off_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            disp_q  <= disp_d;
            msg_q   <= msg_d;
        end
    end

    assign Disp   = disp_q;
    assign Offset = off_q;
    assign Step   = step_q;
    assign Wrap   = wrap_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_word_scroller.sv
// Bench for word_scroller: a cycle-level behavioural model of the message
// ring, compared every cycle, plus hand-computed literal expectations.
module tb_word_scroller;

    localparam int CW = 3;
    localparam int ML = 5;
    localparam int PL = 3;
    localparam int ND = 8;
    localparam int TD = 4;
    localparam int R  = ML + PL;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    mode;
    logic          restart;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [CW-1:0] wr_data;
    logic [ND*CW-1:0] disp;
    logic [2:0]    offset;
    logic          step, wrap, done;

    int tests = 0;
    int fails = 0;

    word_scroller #(
        .CHAR_W   (CW),
        .MSG_LEN  (ML),
        .PAD_LEN  (PL),
        .NUM_DISP (ND),
        .TICK_DIV (TD),
        .BLANK    (3'b111)
    ) dut (
        .Clock   (clk),
        .Resetn  (rst_n),
        .Mode    (mode),
        .Restart (restart),
        .WrEn    (wr_en),
        .WrAddr  (wr_addr),
        .WrData  (wr_data),
        .Disp    (disp),
        .Offset  (offset),
        .Step    (step),
        .Wrap    (wrap),
        .Done    (done)
    );

    always #5 clk = ~clk;

    // Behavioural model: message array, ring offset, step counter, mode phase.
    localparam int S_STOP = 0, S_SCR = 1, S_ONE = 2, S_DONE = 3;
    int m_msg [ML];
    int m_off, m_pre, m_st;
    bit m_step, m_wrap, m_done;
    int n_off, n_pre, n_st;
    bit n_step, n_wrap, n_done;

    always_comb begin
        n_off  = m_off;
        n_pre  = m_pre;
        n_st   = m_st;
        n_done = m_done;
        n_step = 1'b0;
        n_wrap = 1'b0;
        if (mode == 2'd0) begin
            n_st = S_STOP; n_pre = 0; n_done = 1'b0;
            if (restart) n_off = 0;
        end else if (mode != 2'd3) begin
            n_st = S_SCR; n_done = 1'b0;
            if (restart) begin
                n_off = 0; n_pre = 0;
            end else if (m_pre == TD - 1) begin
                n_pre = 0; n_step = 1'b1;
                if (mode == 2'd1) begin
                    n_off  = (m_off + 1) % R;
                    n_wrap = (n_off == 0);
                end else begin
                    n_off  = (m_off + R - 1) % R;
                    n_wrap = (n_off == R - 1);
                end
            end else begin
                n_pre = m_pre + 1;
            end
        end else if (m_st == S_STOP || m_st == S_SCR) begin
            n_st = S_ONE; n_pre = 0; n_off = 0; n_done = 1'b0;
        end else if (m_st == S_ONE) begin
            if (restart) begin
                n_off = 0; n_pre = 0;
            end else if (m_pre == TD - 1) begin
                n_pre = 0; n_step = 1'b1;
                n_off = (m_off + 1) % R;
                if (n_off == 0) begin
                    n_wrap = 1'b1; n_st = S_DONE; n_done = 1'b1;
                end
            end else begin
                n_pre = m_pre + 1;
            end
        end else if (restart) begin
            n_st = S_ONE; n_done = 1'b0; n_off = 0; n_pre = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ML; i++) m_msg[i] <= 7;
            m_off <= 0; m_pre <= 0; m_st <= S_STOP;
            m_step <= 1'b0; m_wrap <= 1'b0; m_done <= 1'b0;
        end else begin
            if (wr_en && wr_addr < ML) m_msg[wr_addr] <= int'(wr_data);
            m_off <= n_off; m_pre <= n_pre; m_st <= n_st;
            m_step <= n_step; m_wrap <= n_wrap; m_done <= n_done;
        end
    end

    function automatic logic [ND*CW-1:0] model_disp();
        logic [ND*CW-1:0] v;
        int idx, c;
        for (int k = 0; k < ND; k++) begin
            idx = (m_off + k) % R;
            c   = (idx < ML) ? m_msg[idx] : 7;
            v[k*CW +: CW] = CW'(c);
        end
        return v;
    endfunction

    function automatic logic [ND*CW-1:0] pack8(input int c0, c1, c2, c3, c4, c5, c6, c7);
        int c [8];
        logic [ND*CW-1:0] v;
        c = '{c0, c1, c2, c3, c4, c5, c6, c7};
        for (int k = 0; k < 8; k++) v[k*CW +: CW] = CW'(c[k]);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: sample on the falling edge and compare against the model.
    task automatic tick();
        @(negedge clk);
        chk("cyc_disp",   32'(disp),   32'(model_disp()));
        chk("cyc_offset", 32'(offset), 32'(m_off));
        chk("cyc_step",   32'(step),   32'(m_step));
        chk("cyc_wrap",   32'(wrap),   32'(m_wrap));
        chk("cyc_done",   32'(done),   32'(m_done));
    endtask

    task automatic wait_step(input int limit, output int cyc);
        cyc = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            cyc++;
            if (step === 1'b1) return;
        end
        tests++;
        fails++;
        $display("FAIL step_timeout actual=no_step required=step_within_%0d", limit);
    endtask

    initial begin
        int cyc, n, nwrap, bad, nst;
        bit got;
        int hello [5];
        hello = '{0, 1, 2, 2, 3};
        mode = 2'd0; restart = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #1 rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("reset_disp",   32'(disp),   32'hFFFFFF);
        chk("reset_offset", 32'(offset), 0);
        chk("reset_done",   32'(done),   0);

        // Load "HELLO" while holding.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = CW'(hello[i]);
            tick();
        end
        wr_en = 1'b0;
        chk("hello_disp", 32'(disp), 32'(pack8(0, 1, 2, 2, 3, 7, 7, 7)));
        chk("hello_offset", 32'(offset), 0);
        n = 0;
        repeat (50) begin tick(); if (step) n++; end
        chk("hold_nostep", n, 0);

        // Scroll left through one full revolution.
        mode = 2'd1;
        wait_step(10, cyc);
        chk("left_latency", cyc, 4);
        chk("left_s1_disp", 32'(disp), 32'(pack8(1, 2, 2, 3, 7, 7, 7, 0)));
        chk("left_s1_offset", 32'(offset), 1);
        nwrap = 0; bad = 0;
        for (int s = 2; s <= 8; s++) begin
            wait_step(10, cyc);
            if (cyc != 4) bad++;
            if (wrap) nwrap++;
        end
        chk("left_period_errs", bad, 0);
        chk("left_wraps", nwrap, 1);
        chk("left_rev_offset", 32'(offset), 0);
        chk("left_rev_disp", 32'(disp), 32'(pack8(0, 1, 2, 2, 3, 7, 7, 7)));

        // Scroll right from offset 0.
        mode = 2'd2;
        wait_step(10, cyc);
        chk("right_offset", 32'(offset), 7);
        chk("right_wrap", 32'(wrap), 1);
        chk("right_disp", 32'(disp), 32'(pack8(7, 0, 1, 2, 2, 3, 7, 7)));

        // One-shot revolution.
        mode = 2'd3;
        nst = 0; got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (step) nst++;
            if (done) begin got = 1'b1; break; end
        end
        chk("oneshot_done_seen", 32'(got), 1);
        chk("oneshot_steps", nst, 8);
        chk("oneshot_offset", 32'(offset), 0);
        chk("oneshot_final_wrap", 32'(wrap), 1);
        n = 0;
        repeat (40) begin tick(); if (step) n++; end
        chk("done_nostep", n, 0);
        chk("done_level", 32'(done), 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_done_clr", 32'(done), 0);
        wait_step(10, cyc);
        chk("restart_latency", cyc, 4);
        chk("restart_offset", 32'(offset), 1);

        // Write coinciding with a left step from offset 7.
        mode = 2'd1;
        for (int i = 0; i < 10 && offset != 3'd7; i++) wait_step(10, cyc);
        chk("reach_off7", 32'(offset), 7);
        tick(); tick(); tick();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 3'd5;
        tick();
        wr_en = 1'b0;
        chk("wrstep_step", 32'(step), 1);
        chk("wrstep_offset", 32'(offset), 0);
        chk("wrstep_pos0", 32'(disp[2:0]), 5);
        chk("wrstep_disp", 32'(disp), 32'(pack8(5, 1, 2, 2, 3, 7, 7, 7)));
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 3'd0;
        tick();
        wr_en = 1'b0;
        chk("ignored_addr6", 32'(disp), 32'(pack8(5, 1, 2, 2, 3, 7, 7, 7)));

        // Asynchronous reset two cycles into a prescale period.
        wait_step(10, cyc);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("areset_disp", 32'(disp), 32'hFFFFFF);
        chk("areset_offset", 32'(offset), 0);
        chk("areset_step", 32'(step), 0);
        tick();
        rst_n = 1'b1;
        wait_step(10, cyc);
        chk("post_reset_latency", cyc, 4);
        chk("post_reset_offset", 32'(offset), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
